// File: rtl/verificador_pkg.sv
// Shared definitions for the board win/tie checker: cell and result codes,
// FSM state encoding and the table of the 8 winning lines.
package verificador_pkg;

    typedef enum logic [1:0] {
        CEL_VAZIA  = 2'b00,
        CEL_X      = 2'b01,
        CEL_O      = 2'b10,
        CEL_EMPATE = 2'b11
    } celula_t;

    localparam logic [1:0] RES_NENHUM = 2'b00;
    localparam logic [1:0] RES_X      = 2'b01;
    localparam logic [1:0] RES_O      = 2'b10;
    localparam logic [1:0] RES_EMPATE = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        LE     = 3'd1,
        ESPERA = 3'd2,
        AVALIA = 3'd3,
        FIM    = 3'd4,
        ERRO   = 3'd5
    } estado_t;

    localparam int         NUM_CELULAS = 9;
    localparam int         NUM_LINHAS  = 8;
    localparam logic [3:0] ULTIMO_IDX  = 4'd8;
    localparam logic [3:0] INDICE_MAX  = 4'd8;

    // Cell indices of every line: rows, columns, then the two diagonals.
    localparam int LINHAS [NUM_LINHAS][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

endpackage

// File: rtl/verificador_tabuleiro_avaliador.sv
// Combinational evaluation of the 8 lines of a 3x3 board.
// Tie detection is compiled only when VERIFICA_EMPATE_EN is defined.
module avaliador_linhas
    import verificador_pkg::*;
(
    input  logic [17:0] celulas,
    output logic [1:0]  resultado
);

    logic ganha_x;
    logic ganha_o;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        ganha_x = 1'b0;
        ganha_o = 1'b0;
        for (int l = 0; l < NUM_LINHAS; l++) begin
            if (celulas[2*LINHAS[l][0] +: 2] == CEL_X &&
                celulas[2*LINHAS[l][1] +: 2] == CEL_X &&
                celulas[2*LINHAS[l][2] +: 2] == CEL_X)
                ganha_x = 1'b1;
            if (celulas[2*LINHAS[l][0] +: 2] == CEL_O &&
                celulas[2*LINHAS[l][1] +: 2] == CEL_O &&
                celulas[2*LINHAS[l][2] +: 2] == CEL_O)
                ganha_o = 1'b1;
        end
    end

`ifdef VERIFICA_EMPATE_EN
    logic cheio;

    always_comb begin
        cheio = 1'b1;
        for (int k = 0; k < NUM_CELULAS; k++) begin
            if (celulas[2*k +: 2] == CEL_VAZIA)
                cheio = 1'b0;
        end
    end
`endif

    // X wins over O when an illegal board has both.
    always_comb begin
        resultado = RES_NENHUM;
        if (ganha_x)
            resultado = RES_X;
        else if (ganha_o)
            resultado = RES_O;
`ifdef VERIFICA_EMPATE_EN
        else if (cheio)
            resultado = RES_EMPATE;
`endif
    end

endmodule

// File: rtl/verificador_tabuleiro.sv
// Sequenced win/tie checker: reads 9 cells from the board RAM or the
// board-state RAM, evaluates all lines and registers the result.
// Optional tie detection: VERIFICA_EMPATE_EN (in avaliador_linhas).
module verificador_tabuleiro
    import verificador_pkg::*;
#(
    parameter int LARGURA_END = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar_verificacao,
    input  logic                   modo_tabuleiro,
    input  logic [3:0]             indice_macro,
    input  logic [1:0]             dado_ram,
    output logic [LARGURA_END-1:0] endereco_ram,
    output logic                   le_ram,
    output logic                   sel_ram,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   erro,
    output logic [1:0]             resultado,
    output logic [2:0]             db_estado
);

    estado_t                estado, proximo;
    logic [3:0]             idx;
    logic [3:0]             indice_reg;
    logic                   modo_reg;
    logic                   captura;
    logic [17:0]            celulas;
    logic [1:0]             resultado_aval;
    logic [LARGURA_END-1:0] base;

    assign base = modo_reg ? '0 : LARGURA_END'(indice_reg) * LARGURA_END'(9);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo      = estado;
        le_ram       = 1'b0;
        endereco_ram = '0;
        ocupado      = 1'b0;
        pronto       = 1'b0;
        erro         = 1'b0;
        db_estado    = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar_verificacao) begin
                    if (modo_tabuleiro || indice_macro <= INDICE_MAX)
                        proximo = LE;
                    else
                        proximo = ERRO;
                end
            end
            LE: begin
                le_ram       = 1'b1;
                ocupado      = 1'b1;
                endereco_ram = base + LARGURA_END'(idx);
                if (idx == ULTIMO_IDX)
                    proximo = ESPERA;
            end
            ESPERA: begin
                ocupado = 1'b1;
                proximo = AVALIA;
            end
            AVALIA: begin
                ocupado = 1'b1;
                proximo = FIM;
            end
            FIM: begin
                ocupado = 1'b1;
                pronto  = 1'b1;
                proximo = OCIOSO;
            end
            ERRO: begin
                erro    = 1'b1;
                proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    // NOTE: the cell register is ordinary flops, not RAM, so it takes the reset like any other state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            indice_reg <= '0;
            modo_reg   <= 1'b0;
            captura    <= 1'b0;
            celulas    <= '0;
            resultado  <= RES_NENHUM;
        end else begin
            if (estado == OCIOSO && proximo == LE) begin
                indice_reg <= indice_macro;
                modo_reg   <= modo_tabuleiro;
            end
            if (estado == LE)
                idx <= (idx == ULTIMO_IDX) ? '0 : idx + 4'd1;
            // RAM data trails the read enable by one cycle; first read lands in cell 0.
            captura <= (estado == LE);
            if (captura)
                celulas <= {dado_ram, celulas[17:2]};
            if (estado == AVALIA)
                resultado <= resultado_aval;
        end
    end

    assign sel_ram = modo_reg;

    avaliador_linhas u_avaliador (
        .celulas   (celulas),
        .resultado (resultado_aval)
    );

endmodule

// File: tb/tb_verificador_tabuleiro.sv
// Self-checking bench for verificador_tabuleiro: directed and random boards
// against a behavioural line-rule model, with a synchronous-read RAM stub.
module tb_verificador_tabuleiro;

    localparam int LARGURA_END = 7;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   iniciar_verificacao;
    logic                   modo_tabuleiro;
    logic [3:0]             indice_macro;
    logic [1:0]             dado_ram = 2'b00;
    logic [LARGURA_END-1:0] endereco_ram;
    logic                   le_ram;
    logic                   sel_ram;
    logic                   ocupado;
    logic                   pronto;
    logic                   erro;
    logic [1:0]             resultado;
    logic [2:0]             db_estado;

    int         erros = 0;
    int         total = 0;
    logic [1:0] res_esperado = 2'b00;
    logic [1:0] ram_tab [0:127];
    logic [1:0] ram_est [0:15];
    logic [1:0] cel [9];

    verificador_tabuleiro #(.LARGURA_END(LARGURA_END)) dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar_verificacao (iniciar_verificacao),
        .modo_tabuleiro      (modo_tabuleiro),
        .indice_macro        (indice_macro),
        .dado_ram            (dado_ram),
        .endereco_ram        (endereco_ram),
        .le_ram              (le_ram),
        .sel_ram             (sel_ram),
        .ocupado             (ocupado),
        .pronto              (pronto),
        .erro                (erro),
        .resultado           (resultado),
        .db_estado           (db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAMs: data appears one cycle after the read enable.
    always @(posedge clock) begin
        if (le_ram)
            dado_ram <= sel_ram ? ram_est[endereco_ram[3:0]] : ram_tab[endereco_ram];
    end

    task automatic check(input string nome, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        assert (obs === esp)
        else begin
            erros++;
            $error("FAIL %s: observed=%0h expected=%0h", nome, obs, esp);
        end
    endtask

    // Reference: a player wins with three equal own marks on any row, column or diagonal.
    function automatic logic [1:0] modelo(input logic [1:0] c [9]);
        int  lin [8][3];
        bit  wx;
        bit  wo;
        bit  cheio;
        wx    = 0;
        wo    = 0;
        cheio = 1;
        for (int i = 0; i < 3; i++) begin
            lin[i]     = '{3*i, 3*i + 1, 3*i + 2};
            lin[3 + i] = '{i, i + 3, i + 6};
        end
        lin[6] = '{0, 4, 8};
        lin[7] = '{2, 4, 6};
        for (int l = 0; l < 8; l++) begin
            if (c[lin[l][0]] == c[lin[l][1]] && c[lin[l][1]] == c[lin[l][2]]) begin
                if (c[lin[l][0]] == 2'b01) wx = 1;
                if (c[lin[l][0]] == 2'b10) wo = 1;
            end
        end
        for (int k = 0; k < 9; k++)
            if (c[k] == 2'b00) cheio = 0;
        if (wx) return 2'b01;
        if (wo) return 2'b10;
`ifdef VERIFICA_EMPATE_EN
        if (cheio) return 2'b11;
`else
        if (cheio) return 2'b00;
`endif
        return 2'b00;
    endfunction

    task automatic executa(input string tag, input logic modo, input logic [3:0] ind,
                           input logic [1:0] c [9], input bit repulsa);
        logic [LARGURA_END-1:0] ends[$];
        int         n_le, n_pronto, k_pronto, n_erro, k_erro, base;
        logic [1:0] res_pronto, esp;
        logic       sel_obs, ocup1, ocup12, ocup13;
        bit         invalido;
        n_le = 0; n_pronto = 0; k_pronto = -1; n_erro = 0; k_erro = -1;
        res_pronto = 2'b00; sel_obs = 1'b0; ocup1 = 1'b0; ocup12 = 1'b0; ocup13 = 1'b1;
        invalido = !modo && ind > 4'd8;
        base     = modo ? 0 : int'(ind) * 9;
        for (int i = 0; i < 9; i++) begin
            if (modo) ram_est[i] = c[i];
            else if (!invalido) ram_tab[base + i] = c[i];
        end
        @(negedge clock);
        iniciar_verificacao = 1'b1;
        modo_tabuleiro      = modo;
        indice_macro        = ind;
        @(negedge clock);
        iniciar_verificacao = 1'b0;
        modo_tabuleiro      = 1'($urandom);
        indice_macro        = 4'($urandom);
        for (int k = 1; k <= 16; k++) begin
            if (le_ram) begin
                ends.push_back(endereco_ram);
                n_le++;
                sel_obs = sel_ram;
            end
            if (pronto) begin
                n_pronto++;
                k_pronto   = k;
                res_pronto = resultado;
                ocup12     = ocupado;
            end
            if (erro) begin
                n_erro++;
                k_erro = k;
            end
            if (k == 1) ocup1 = ocupado;
            if (k_pronto > 0 && k == k_pronto + 1) ocup13 = ocupado;
            if (repulsa && k == 4) iniciar_verificacao = 1'b1;
            if (k == 5) iniciar_verificacao = 1'b0;
            @(negedge clock);
        end
        if (invalido) begin
            check({tag, " erro_count"}, n_erro, 1);
            check({tag, " erro_cycle"}, k_erro, 1);
            check({tag, " le_count"}, n_le, 0);
            check({tag, " pronto_count"}, n_pronto, 0);
            check({tag, " resultado_held"}, 32'(resultado), 32'(res_esperado));
        end else begin
            esp = modelo(c);
            check({tag, " le_count"}, n_le, 9);
            foreach (ends[i])
                check({tag, " addr"}, 32'(ends[i]), base + i);
            check({tag, " sel_ram"}, 32'(sel_obs), 32'(modo));
            check({tag, " pronto_count"}, n_pronto, 1);
            check({tag, " pronto_cycle"}, k_pronto, 12);
            check({tag, " resultado"}, 32'(res_pronto), 32'(esp));
            check({tag, " ocupado_first"}, 32'(ocup1), 1);
            check({tag, " ocupado_pronto"}, 32'(ocup12), 1);
            check({tag, " ocupado_after"}, 32'(ocup13), 0);
            check({tag, " erro_count"}, n_erro, 0);
            check({tag, " resultado_held"}, 32'(resultado), 32'(esp));
            res_esperado = esp;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " le_ram"}, 32'(le_ram), 0);
        check({tag, " endereco"}, 32'(endereco_ram), 0);
        check({tag, " sel_ram"}, 32'(sel_ram), 0);
        check({tag, " ocupado"}, 32'(ocupado), 0);
        check({tag, " pronto"}, 32'(pronto), 0);
        check({tag, " erro"}, 32'(erro), 0);
        check({tag, " resultado"}, 32'(resultado), 0);
        check({tag, " db_estado"}, 32'(db_estado), 0);
    endtask

    initial begin
        int n_pr;
        reset               = 1'b1;
        iniciar_verificacao = 1'b0;
        modo_tabuleiro      = 1'b0;
        indice_macro        = 4'd0;
        for (int i = 0; i < 128; i++) ram_tab[i] = 2'($urandom);
        for (int i = 0; i < 16; i++)  ram_est[i] = 2'($urandom);
        #12;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        cel = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        executa("micro_row", 1'b0, 4'd4, cel, 1'b0);

        cel = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        executa("board_diag", 1'b1, 4'd0, cel, 1'b0);

        cel = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        executa("full_noowin", 1'b0, 4'd8, cel, 1'b0);

        executa("bad_index", 1'b0, 4'd9, cel, 1'b0);

        cel = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        executa("repulse", 1'b0, 4'd0, cel, 1'b1);

        // Reset in the middle of a run: everything clears, no done pulse follows.
        cel = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 9; i++) ram_tab[18 + i] = cel[i];
        @(negedge clock);
        iniciar_verificacao = 1'b1;
        modo_tabuleiro      = 1'b0;
        indice_macro        = 4'd2;
        @(negedge clock);
        iniciar_verificacao = 1'b0;
        n_pr = 0;
        for (int k = 1; k < 7; k++) begin
            if (pronto) n_pr++;
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        check_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (pronto) n_pr++;
            @(negedge clock);
        end
        check("midreset no_pronto", n_pr, 0);
        res_esperado = 2'b00;

        for (int i = 0; i < 9; i++) cel[i] = 2'b11;
        executa("all_tied", 1'b1, 4'd0, cel, 1'b0);

        cel = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
        executa("col0_x", 1'b1, 4'd0, cel, 1'b0);

        for (int r = 0; r < 24; r++) begin
            logic       m;
            logic [3:0] ind;
            int         ln;
            m   = 1'($urandom_range(0, 1));
            ind = 4'($urandom_range(0, 10));
            for (int i = 0; i < 9; i++) cel[i] = 2'($urandom);
            // Plant a complete line in about half the runs so wins are common.
            if ($urandom_range(0, 1) == 1) begin
                ln = $urandom_range(0, 2);
                cel[3*ln] = 2'($urandom_range(1, 2));
                cel[3*ln + 1] = cel[3*ln];
                cel[3*ln + 2] = cel[3*ln];
            end
            executa("random", m, ind, cel, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end

endmodule

// File: doc/verificador_tabuleiro.md
# verificador_tabuleiro

Sequenced win/tie checker for the ultimate tic-tac-toe datapath. On a start pulse it reads the 9 cells of one micro board from the board RAM, or the 9 macro results from the board-state RAM, one address per cycle. It then evaluates all 8 lines and returns a registered result. The main control unit triggers it in its `verifica_macro` and `verifica_tabuleiro` phases.

## Interface
Parameters:
- `LARGURA_END`, 7: board RAM address width (81 cells).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `iniciar_verificacao` in 1: start pulse; sampled only in `OCIOSO`.
- `modo_tabuleiro` in 1: 0 = check micro board `indice_macro`; 1 = check board-state RAM. Sampled with start.
- `indice_macro` in 4: micro board index 0..8. Sampled with start.
- `dado_ram` in 2: RAM read data, valid 1 cycle after `le_ram`.
- `endereco_ram` out `LARGURA_END`: read address.
- `le_ram` out 1: read enable.
- `sel_ram` out 1: 0 = board RAM, 1 = board-state RAM.
- `ocupado` out 1: high from the cycle after start until `pronto`, inclusive.
- `pronto` out 1: one-cycle done pulse.
- `erro` out 1: one-cycle pulse on an invalid index.
- `resultado` out 2: 00 none, 01 X wins, 10 O wins, 11 tie. Held until the next accepted start.
- `db_estado` out 3: current state code.

## Operation
- Cell encoding: 00 empty, 01 X, 10 O, 11 tied macro. 11 counts as occupied and belongs to no player.
- State encoding:
  - `OCIOSO`=0
  - `LE`=1
  - `ESPERA`=2
  - `AVALIA`=3
  - `FIM`=4
  - `ERRO`=5
- State transitions:
  - `OCIOSO` to `LE` on start, with valid index or `modo_tabuleiro`=1.
  - `OCIOSO` to `ERRO` on start with `modo_tabuleiro`=0 and `indice_macro`>8.
  - `ERRO` to `OCIOSO`.
  - `LE` stays in `LE` while read counter `idx`<8; goes to `ESPERA` after `idx`=8.
  - `ESPERA` to `AVALIA`, `AVALIA` to `FIM`, `FIM` to `OCIOSO`.
- Address generation:
  - In `LE`, `endereco_ram` = base + `idx`, with `le_ram`=1.
  - Base = `indice_macro`*9 in micro mode (max 8*9+8=80), 0 in board mode. Base is computed zero-extended to `LARGURA_END`.
  - `sel_ram` = latched `modo_tabuleiro`.
- Capture: each returning `dado_ram` is shifted into an 18-bit cell register. Cell k = read index k.
- Evaluation in `AVALIA` covers 8 lines: 3 rows, 3 columns, 2 diagonals.
  - A line wins if all 3 cells are 01, or all are 10.
  - If both players have a winning line (illegal board), 01 takes priority.
  - Tie = no winner and all 9 cells ≠ 00.
  - `resultado` registers at the end of `AVALIA`.
- `iniciar_verificacao` outside `OCIOSO` is ignored. `indice_macro` and `modo_tabuleiro` changes after start are ignored.
- Reset values:
  - State `OCIOSO`, `idx`=0, cell register 0.
  - All outputs 0, including `resultado`=00 and `db_estado`=0.
- Reset mid-operation aborts immediately. No `pronto` is produced.

## Timing
Start is sampled high at edge T. `ocupado` rises at T+1.

| Cycles | Phase | Activity |
|---|---|---|
| T+1..T+9 | `LE` | Addresses base+0..base+8 issued, `le_ram`=1 |
| T+2..T+10 | `LE` / `ESPERA` | Data captured, ending in `ESPERA` |
| T+11 | `AVALIA` | Result computed |
| T+12 | `FIM` | `pronto`=1; new `resultado` visible; `ocupado` still 1 |
| T+13 | `OCIOSO` | Earliest next start accepted |

- Latency from start to `pronto` is 12 cycles.
- `le_ram` is high for exactly 9 consecutive cycles.
- Invalid index: `erro`=1 at T+1, back in `OCIOSO` at T+2. `resultado` is unchanged and no RAM read occurs.
- No write ports: the block never asserts any RAM write enable.

## Configuration
Macro `VERIFICA_EMPATE_EN`:
- Defined: the tie code 11 is produced as described.
- Undefined: the tie logic is not compiled. A full board with no winner yields 00. Cell code 11 is still treated as non-owner.

## Structure
- Shared package `verificador_pkg`:
  - cell codes
  - result codes
  - state encoding
  - constant 9-cell line index table (8×3 indices)
- One combinational sub-module, `avaliador_linhas`: 18-bit cells in, `resultado` out. It contains the `ifdef VERIFICA_EMPATE_EN` logic.
- The FSM, counter, address adder and capture register live in the top module.

## Test plan
1. Micro mode, `indice_macro`=4, cells 0,1,2 = 01, rest 00:
   - Addresses 36..44 on T+1..T+9.
   - `pronto` at T+12 with `resultado`=01.
2. Board mode, cells 2,4,6 = 10:
   - `sel_ram`=1, addresses 0..8.
   - `resultado`=10.
3. Micro mode, full board 01,10,01 / 01,10,10 / 10,01,01:
   - `resultado`=11 with `VERIFICA_EMPATE_EN`, 00 without.
4. `indice_macro`=9, micro mode:
   - `erro` pulse at T+1.
   - `le_ram` never asserted.
   - `resultado` unchanged.
5. Start re-pulsed at T+5:
   - Ignored; single `pronto` at T+12.
   - Reset at T+7 of a new run: outputs 0, no `pronto`.
6. Board mode, all 11:
   - `resultado`=11 with the macro defined.
   - Column 0 = 01 with everything else 11: `resultado`=01.
